clk_div_ctrl: RTL



---
 rtl/clk_div_pkg.sv | 30 +++
 rtl/clk_div_core.sv | 70 +++++++
 rtl/clk_div_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : clk_div_pkg                                          |
// | Description : Shared types and helpers for the runtime-            |
// |               reconfigurable clock divider (controller FSM states, |
// |               minimum legal ratio, ratio legality check).          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package clk_div_pkg;

  // Controller state. STOPPING keeps the divider running until the
  // current output period has completed, so clk_out never truncates.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  // Smallest ratio that still yields a full high and low phase.
  localparam int unsigned DIV_MIN = 2;

  // Callers zero-extend their ratio into 32 bits so one helper serves
  // any ratio width.
  function automatic logic div_legal(input logic [31:0] div);
    return (div >= DIV_MIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : clk_div_core                                         |
// | Description : Divider datapath: period counter, posedge/negedge    |
// |               phase registers and the odd/even 50% duty mux.       |
// | Ports       : clk, rst_n      - source clock, async active-low rst |
// |               run_i           - counter enabled (state not IDLE)   |
// |               load_i          - new ratio applied this edge        |
// |               div_i           - ratio currently in effect          |
// |               boundary_o      - last source cycle of the period    |
// |               clk_out_o       - divided clock                      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module clk_div_core #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             boundary_o,
  output logic             clk_out_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_p_q, clk_p_d;
  logic             clk_n_q;

  assign boundary_o = run_i && (cnt_q == (div_i - DIV_W'(1)));

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!run_i || load_i || boundary_o) begin
      cnt_d = '0;
    end
    // Phase is derived from the count the register will hold, so clk_p
    // is aligned with cnt and drops low on the very edge a period wraps.
    // A legal ratio is >= 2, so a zero count always yields clk_p = 0,
    // which also keeps it low throughout IDLE.
    clk_p_d = (cnt_d >= (div_i >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clk_p_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clk_p_q <= clk_p_d;
    end
  end

  // Half-cycle delayed copy of clk_p; ANDing trims the first half cycle
  // of the high phase so odd ratios come out at exactly 50% duty.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_p_q;
    end
  end

  // div_i[0] only changes on a boundary edge, where clk_p is already 0,
  // so switching the mux leg cannot create a glitch.
  assign clk_out_o = div_i[0] ? (clk_p_q & clk_n_q) : clk_p_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : clk_div_ctrl                                         |
// | Description : Runtime-reconfigurable integer clock divider. Owns   |
// |               the divide ratio, accepts new ratios over valid/     |
// |               ready and applies them only on a period boundary.    |
// | Ports       : clk, rst_n  - source clock, async active-low reset   |
// |               en          - run request (level)                    |
// |               cfg_valid/cfg_div/cfg_ready - ratio handshake        |
// |               cfg_err     - pulse, offered ratio rejected          |
// |               busy        - running or a ratio change pending      |
// |               cur_div     - ratio in effect                        |
// |               tick        - pulse after last cycle of each period  |
// |               clk_out     - divided clock                          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 12,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic             tick,
  output logic             clk_out
);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             cfg_err_q, cfg_err_d;
  logic             tick_q;
  logic             w_boundary;
  logic             w_xfer;
  logic             w_legal;
  logic             w_apply;

  assign w_xfer  = cfg_valid && !pend_q;
  assign w_legal = div_legal(32'(cfg_div));
  // pend blocks new transfers, so an apply and a transfer never coincide.
  assign w_apply = w_boundary && pend_q;

  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    cfg_err_d  = w_xfer && !w_legal;

    unique case (state_q)
      ST_IDLE:     if (en) state_d = ST_RUN;
      ST_RUN:      if (!en) state_d = ST_STOPPING;
      ST_STOPPING: begin
        if (en)              state_d = ST_RUN;
        else if (w_boundary) state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase

    if (w_apply) begin
      cur_div_d = pend_div_q;
      pend_d    = 1'b0;
    end

    // With the divider stopped there is no period to protect, so the
    // ratio takes effect straight away; otherwise it waits for a boundary.
    if (w_xfer && w_legal) begin
      if (state_q == ST_IDLE) begin
        cur_div_d = cfg_div;
      end else begin
        pend_d     = 1'b1;
        pend_div_d = cfg_div;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_div_q  <= DIV_W'(DEF_DIV);
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      cfg_err_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      cfg_err_q  <= cfg_err_d;
      tick_q     <= w_boundary;
    end
  end

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (state_q != ST_IDLE),
    .load_i     (w_apply),
    .div_i      (cur_div_q),
    .boundary_o (w_boundary),
    .clk_out_o  (clk_out)
  );

  assign cfg_ready = !pend_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q != ST_IDLE) || pend_q;
  assign cur_div   = cur_div_q;
  assign tick      = tick_q;

endmodule
`default_nettype wire
